// File: rtl/imem_ctrl.sv
// Instruction memory controller: word-addressed instruction store with a
// loader write port and a valid/ready fetch port with configurable latency.
// Fetch addresses are checked for misalignment and range before the array
// read; faulting fetches return FILL with a fault code.
module imem_ctrl #(
    parameter int          DEPTH   = 64,
    parameter int          LATENCY = 1,
    parameter logic [31:0] FILL    = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_fault,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        busy
);

    localparam int          AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W        = 30'(DEPTH);
    localparam logic [2:0]  CNT_INIT       = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;
    localparam logic [1:0]  FAULT_OK       = 2'b00;
    localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
    localparam logic [1:0]  FAULT_RANGE    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Classify a byte address: misalignment takes priority over range.
    function automatic logic [1:0] addr_fault(input logic [31:0] addr);
        logic [1:0] f;
        if (addr[1:0] != 2'b00) begin
            f = FAULT_MISALIGN;
        end else if (addr[31:2] >= DEPTH_W) begin
            f = FAULT_RANGE;
        end else begin
            f = FAULT_OK;
        end
        return f;
    endfunction

    // Content is FILL from power-up only; reset deliberately leaves it alone.
    logic [31:0] mem_q [DEPTH] = '{default: FILL};

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [31:0] rsp_data_q;
    logic [1:0]  rsp_fault_q;
    logic        rsp_valid_q;
    logic        busy_q;

    logic [1:0]  rd_fault_d;
    logic [31:0] rd_data_d;
    logic        wr_ok_s;

    assign req_ready = (state_q == IDLE) && !reset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_fault = rsp_fault_q;
    assign busy      = busy_q;

    assign wr_ok_s = wr_en && !reset && (addr_fault(wr_addr) == FAULT_OK);

    // Response word and fault code that an acceptance this cycle would capture.
    always_comb begin
        rd_fault_d = addr_fault(req_addr);
        rd_data_d  = FILL;
        if (rd_fault_d == FAULT_OK) begin
            rd_data_d = mem_q[req_addr[AW+1:2]];
        end else begin
            rd_data_d = FILL;
        end
    end

    // Loader write port; the array read above sees the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_addr[AW+1:2]] <= wr_data;
        end
    end

    // Fetch FSM: accept in IDLE, count out the latency, hold until consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            rsp_data_q  <= 32'd0;
            rsp_fault_q <= 2'b00;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        rsp_data_q  <= rd_data_d;
                        rsp_fault_q <= rd_fault_d;
                        busy_q      <= 1'b1;
                        if (LATENCY == 1) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= 3'd0;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: three instances (LATENCY 1, 2, 4) share clock and
// reset. A word-array model computes expected fetch results, fault codes
// and response latency from the address rules.
module tb_imem_ctrl;

    localparam logic [31:0] FILL  = 32'h00000013;
    localparam int          DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [3];
    logic        req_ready [3];
    logic [31:0] req_addr  [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_data  [3];
    logic [1:0]  rsp_fault [3];
    logic        wr_en     [3];
    logic [31:0] wr_addr   [3];
    logic [31:0] wr_data   [3];
    logic        busy      [3];

    logic [31:0] mdl [3][DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        imem_ctrl #(
            .DEPTH  (DEPTH),
            .LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
            .FILL   (FILL)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_addr (req_addr[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_data (rsp_data[g]),
            .rsp_fault(rsp_fault[g]),
            .wr_en    (wr_en[g]),
            .wr_addr  (wr_addr[g]),
            .wr_data  (wr_data[g]),
            .busy     (busy[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    function automatic logic [1:0] exp_fault(input logic [31:0] a);
        if ((a % 32'd4) != 32'd0) return 2'b01;
        if ((a / 32'd4) >= 32'(DEPTH)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_data(input int k, input logic [31:0] a);
        if (exp_fault(a) != 2'b00) return FILL;
        return mdl[k][int'(a / 32'd4)];
    endfunction

    // Advance to the next falling edge and fold in any write that the
    // rising edge just committed.
    task automatic tick(input int k);
        @(negedge clk);
        if (wr_en[k] && !reset && exp_fault(wr_addr[k]) == 2'b00) begin
            mdl[k][int'(wr_addr[k] / 32'd4)] = wr_data[k];
        end
        wr_en[k] = 1'b0;
    endtask

    task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d);
        wr_en[k] = 1'b1; wr_addr[k] = a; wr_data[k] = d;
        tick(k);
    endtask

    task automatic fetch(input int k, input logic [31:0] a, input int hold, input bit rnd);
        logic [31:0] ed;
        logic [1:0]  ef;
        int          cyc;
        ed = exp_data(k, a);
        ef = exp_fault(a);
        n_checks++;
        if (req_ready[k] !== 1'b1) begin
            n_fail++; $display("FAIL ready_idle: inst %0d got %b expected 1", k, req_ready[k]);
        end
        req_valid[k] = 1'b1; req_addr[k] = a; rsp_ready[k] = (hold == 0);
        tick(k);
        req_valid[k] = 1'b0;
        cyc = 1;
        while (rsp_valid[k] !== 1'b1 && cyc < 20) begin
            if (rnd) begin
                req_valid[k] = 1'($urandom_range(0, 1)); req_addr[k] = $urandom;
                if ($urandom_range(0, 1) == 1) begin
                    wr_en[k] = 1'b1; wr_addr[k] = {a[31:2], 2'b00}; wr_data[k] = $urandom;
                end
            end
            tick(k);
            cyc++;
        end
        n_checks++;
        if (cyc != lat_of(k)) begin
            n_fail++; $display("FAIL latency: inst %0d addr %h got %0d cycles expected %0d", k, a, cyc, lat_of(k));
        end
        for (int h = 0; h <= hold; h++) begin
            n_checks++;
            if (rsp_valid[k] !== 1'b1 || rsp_data[k] !== ed || rsp_fault[k] !== ef || busy[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL resp: inst %0d addr %h hold %0d got v=%b d=%h f=%b busy=%b expected v=1 d=%h f=%b busy=1",
                         k, a, h, rsp_valid[k], rsp_data[k], rsp_fault[k], busy[k], ed, ef);
            end
            if (h < hold) begin
                if (rnd) begin
                    req_valid[k] = 1'($urandom_range(0, 1)); req_addr[k] = $urandom;
                    wr_en[k] = 1'b1; wr_addr[k] = {a[31:2], 2'b00}; wr_data[k] = $urandom;
                end
                tick(k);
            end
        end
        rsp_ready[k] = 1'b1;
        tick(k);
        req_valid[k] = 1'b0;
        n_checks++;
        if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_idle: inst %0d got v=%b ready=%b busy=%b expected v=0 ready=1 busy=0",
                     k, rsp_valid[k], req_ready[k], busy[k]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rsp_valid[k] !== 1'b0 || rsp_data[k] !== 32'd0 || rsp_fault[k] !== 2'b00 ||
                busy[k] !== 1'b0 || req_ready[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: inst %0d got v=%b d=%h f=%b busy=%b ready=%b expected all zero",
                         k, rsp_valid[k], rsp_data[k], rsp_fault[k], busy[k], req_ready[k]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (req_ready[k] !== 1'b1) begin
                n_fail++; $display("FAIL ready_after_reset: inst %0d got %b expected 1", k, req_ready[k]);
            end
        end
    endtask

    task automatic test_directed();
        do_write(1, 32'h0, 32'h00500113);
        fetch(1, 32'h0, 0, 1'b0);
        fetch(0, 32'h6, 0, 1'b0);
        fetch(0, 32'h100, 0, 1'b0);
        fetch(1, 32'h0, 5, 1'b1);
    endtask

    task automatic test_rd_before_wr();
        do_write(1, 32'h8, 32'h00C00193);
        wr_en[1] = 1'b1; wr_addr[1] = 32'h8; wr_data[1] = 32'hDEADBEEF;
        fetch(1, 32'h8, 0, 1'b0);
        fetch(1, 32'h8, 0, 1'b0);
    endtask

    task automatic test_abort();
        fetch(2, 32'h0, 0, 1'b0);
        req_valid[2] = 1'b1; req_addr[2] = 32'h4;
        tick(2);
        req_valid[2] = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        n_checks++;
        if (rsp_valid[2] !== 1'b0 || rsp_data[2] !== 32'd0 || busy[2] !== 1'b0 || req_ready[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_in_reset: got v=%b d=%h busy=%b ready=%b expected 0 0 0 0",
                     rsp_valid[2], rsp_data[2], busy[2], req_ready[2]);
        end
        reset = 1'b0;
        tick(2);
        n_checks++;
        if (req_ready[2] !== 1'b1) begin
            n_fail++; $display("FAIL abort_ready: got %b expected 1", req_ready[2]);
        end
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (rsp_valid[2] === 1'b1) seen = 1'b1;
                tick(2);
            end
            n_checks++;
            if (seen) begin
                n_fail++; $display("FAIL abort_no_rsp: got rsp_valid=1 expected never");
            end
        end
    endtask

    task automatic test_sweep(input int k);
        for (int i = 0; i < 16; i++) begin
            do_write(k, 32'($urandom_range(0, DEPTH - 1)) * 32'd4, $urandom);
        end
        do_write(k, 32'h102, 32'h11111111);
        do_write(k, 32'h400, 32'h22222222);
        for (int w = 0; w < DEPTH; w++) begin
            fetch(k, 32'(w) * 32'd4, 0, 1'b0);
        end
    endtask

    task automatic test_random(input int k);
        logic [31:0] a;
        int          mode;
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 3);
            if (mode <= 1) begin
                a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
            end else if (mode == 2) begin
                a = $urandom & 32'h1FF;
                if ((a % 32'd4) == 32'd0) a = a + 32'd1;
            end else begin
                a = 32'h100 + ($urandom & 32'h7FFFFFFC);
            end
            if ($urandom_range(0, 3) == 0) begin
                do_write(k, ($urandom_range(0, 1) == 1) ? $urandom : (32'($urandom_range(0, 70)) * 32'd4), $urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                wr_en[k] = 1'b1; wr_addr[k] = {a[31:2], 2'b00}; wr_data[k] = $urandom;
            end
            fetch(k, a, $urandom_range(0, 3), 1'b1);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_addr[k] = 32'd0; rsp_ready[k] = 1'b1;
            wr_en[k] = 1'b0; wr_addr[k] = 32'd0; wr_data[k] = 32'd0;
            for (int w = 0; w < DEPTH; w++) mdl[k][w] = FILL;
        end
        test_reset();
        test_directed();
        test_rd_before_wr();
        test_abort();
        for (int k = 0; k < 3; k++) test_sweep(k);
        for (int k = 0; k < 3; k++) test_random(k);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit instruction words.
REQ-002 The block SHALL have parameter LATENCY, default 1, legal range 1..8, meaning the cycles from request acceptance to the first rsp_valid.
REQ-003 The block SHALL have parameter FILL, default 32'h00000013 (NOP), meaning the power-up content of every word and the data returned on a fault.
REQ-004 The block SHALL have port clk  in  1  meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  in  1  meaning a synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid  in  1  meaning that a fetch request is present.
REQ-007 The block SHALL have port req_ready  out  1  meaning that the block accepts a request this cycle.
REQ-008 The block SHALL have port req_addr  in  32  meaning the byte address of the fetch.
REQ-009 The block SHALL have port rsp_valid  out  1  meaning that the response is valid.
REQ-010 The block SHALL have port rsp_ready  in  1  meaning that the consumer takes the response.
REQ-011 The block SHALL have port rsp_data  out  32  meaning the instruction word.
REQ-012 The block SHALL have port rsp_fault  out  2  meaning 00 ok, 01 misaligned, 10 out of range.
REQ-013 The block SHALL have port wr_en  in  1  meaning a loader write strobe.
REQ-014 The block SHALL have port wr_addr  in  32  meaning the loader byte address.
REQ-015 The block SHALL have port wr_data  in  32  meaning the loader write word.
REQ-016 The block SHALL have port busy  out  1  meaning that the state is not IDLE.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, WAIT and RESP, and req_ready SHALL equal (state==IDLE && !reset).
REQ-018 Acceptance SHALL occur when req_valid and req_ready are both high; on the acceptance edge the block SHALL register rsp_data and rsp_fault, reading the array at req_addr[31:2].
REQ-019 The fault check SHALL be: req_addr[1:0]!=0 gives fault 01 (priority); otherwise req_addr[31:2]>=DEPTH gives fault 10; on any fault rsp_data SHALL be FILL.
REQ-020 On acceptance with LATENCY==1 the FSM SHALL go to RESP; otherwise it SHALL go to WAIT with a down-counter loaded with LATENCY-2.
REQ-021 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL go to RESP when the counter is 0.
REQ-022 rsp_valid SHALL be high only in RESP, first in cycle N=LATENCY after the acceptance cycle (cycle 0).
REQ-023 In RESP, rsp_valid, rsp_data and rsp_fault SHALL hold stable until rsp_ready is high; the FSM SHALL then go to IDLE on that edge.
REQ-024 A request SHALL NOT be accepted in the rsp handshake cycle; minimum throughput SHALL be one fetch per LATENCY+1 cycles.
REQ-025 A write SHALL update word wr_addr[31:2] on the edge when wr_en is high, wr_addr[1:0]==0, wr_addr[31:2]<DEPTH and reset is low; any other write SHALL be silently dropped.
REQ-026 Writes SHALL be accepted in every state and SHALL be independent of the fetch handshake.
REQ-027 When a write and an acceptance target the same word in the same cycle, the response SHALL return the old data (read-before-write).
REQ-028 A write to a word already captured for a pending response SHALL NOT alter rsp_data.
REQ-029 A change of req_addr or req_valid while the FSM is not in IDLE SHALL be ignored.

Reset
REQ-030 While reset is high, state SHALL be IDLE and the counter 0, with rsp_valid=0, rsp_data=0, rsp_fault=00 and busy=0.
REQ-031 Reset asserted in WAIT or RESP SHALL abort the pending fetch; no rsp_valid SHALL follow it.
REQ-032 Reset SHALL NOT alter array contents; all words SHALL hold FILL only at time zero.
REQ-033 req_ready SHALL be high in the first cycle after reset deasserts.

Verification
REQ-034 With LATENCY=2, write 0x00500113 to address 0x0, then fetch 0x0 with rsp_ready=1 -> rsp_valid high in cycle 2 only, rsp_data=0x00500113, fault 00, req_ready high again in cycle 3.
REQ-035 With LATENCY=1, fetch 0x6 -> fault 01, data 0x00000013; fetch 0x100 with DEPTH=64 -> fault 10, data 0x00000013.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_fault stay constant, busy=1, and req_valid is ignored; rsp_ready=1 -> IDLE next cycle.
REQ-037 In the same cycle, write 0xDEADBEEF to 0x8 and accept a fetch of 0x8 holding 0x00C00193 -> response is 0x00C00193; the next fetch of 0x8 returns 0xDEADBEEF.
REQ-038 With LATENCY=4, assert reset for 1 cycle in WAIT -> rsp_valid never rises, and req_ready=1 in the cycle after reset.
REQ-039 With wr_addr=0x102 (misaligned) or 0x400 (out of range) and wr_en=1 -> no word changes, checked by sweeping reads of all 64 words.
